// File: rtl/kpn_queue_receiver.sv
// Receiving end of a KPN channel: strobed writes into a circular FIFO,
// drained through a read-request/valid handshake with occupancy and overflow status.
module kpn_queue_receiver #(
    parameter int BITS_NUMBER   = 16,
    parameter int FIFO_ELEMENTS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [BITS_NUMBER-1:0]   input_1,
    input  logic                     rd,
    output logic [BITS_NUMBER-1:0]   output_1,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [FIFO_ELEMENTS:0]   count,
    output logic                     overflow
);

    localparam int DEPTH = 2 ** FIFO_ELEMENTS;
    localparam logic [FIFO_ELEMENTS:0] MAX_COUNT = {1'b1, {FIFO_ELEMENTS{1'b0}}};

    logic [BITS_NUMBER-1:0]   mem [DEPTH];
    logic [FIFO_ELEMENTS-1:0] w_ptr;
    logic [FIFO_ELEMENTS-1:0] r_ptr;
    logic                     wa;
    logic                     ra;

    assign full  = (count == MAX_COUNT);
    assign empty = (count == '0);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wa = wr & (~full | rd);
    assign ra = rd & ~empty;

    always_ff @(posedge clk) begin
        if (wa) begin
            mem[w_ptr] <= input_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            output_1 <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= ra;
            if (wa) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (ra) begin
                output_1 <= mem[r_ptr];
                r_ptr    <= r_ptr + 1'b1;
            end
            if (wa && !ra) begin
                count <= count + 1'b1;
            end else if (ra && !wa) begin
                count <= count - 1'b1;
            end
            if (wr && full && !rd) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kpn_queue_receiver.sv
// Directed bench for kpn_queue_receiver with a queue scoreboard
// holding the words the FIFO should currently contain.
module tb_kpn_queue_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] input_1 = '0;
    logic        rd = 1'b0;
    logic [15:0] output_1;
    logic        valid;
    logic        full;
    logic        empty;
    logic [5:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] last_out = '0;
    logic        m_ovf = 1'b0;

    kpn_queue_receiver #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .input_1(input_1), .rd(rd),
        .output_1(output_1), .valid(valid), .full(full), .empty(empty),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(sb.size()));
        chk({tag, "_full"}, 32'(full), 32'(sb.size() == 32));
        chk({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one edge worth of strobes; model predicts acceptance from its own occupancy.
    task automatic cycle(input logic w, input logic [15:0] d, input logic r);
        logic        m_wa;
        logic        m_ra;
        logic [15:0] exp_out;
        m_wa = w && (sb.size() < 32 || r);
        m_ra = r && sb.size() > 0;
        if (w && sb.size() == 32 && !r) m_ovf = 1'b1;
        exp_out = last_out;
        if (m_ra) exp_out = sb.pop_front();
        if (m_wa) sb.push_back(d);
        wr = w;
        input_1 = d;
        rd = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        chk("valid", 32'(valid), 32'(m_ra));
        chk("output_1", 32'(output_1), 32'(exp_out));
        last_out = exp_out;
        chk_status("cyc");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #2;
        sb.delete();
        m_ovf = 1'b0;
        last_out = '0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_out", 32'(output_1), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic w;
        logic r;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // Single transfer
        cycle(1'b1, 16'h00A5, 1'b0);
        chk("single_cnt1", 32'(count), 32'd1);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("single_data", 32'(output_1), 32'h00A5);
        chk("single_empty", 32'(empty), 32'd1);
        cycle(1'b0, 16'h0000, 1'b0);

        // Read on empty: output holds
        repeat (5) cycle(1'b0, 16'h0000, 1'b1);
        chk("rdempty_hold", 32'(output_1), 32'h00A5);

        // Empty with simultaneous wr and rd: no bypass
        cycle(1'b1, 16'h1234, 1'b1);
        chk("emptyboth_valid", 32'(valid), 32'd0);
        chk("emptyboth_cnt", 32'(count), 32'd1);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("emptyboth_data", 32'(output_1), 32'h1234);

        // Pointer wrap: 100 words, occupancy held in 3..10
        n = 0;
        while (n < 3) begin
            cycle(1'b1, 16'(n), 1'b0);
            n++;
        end
        while (n < 100) begin
            r = (sb.size() > 3) && ($urandom_range(1) == 1);
            w = (sb.size() < 10) && ($urandom_range(1) == 1);
            if (!w && !r) begin
                if (sb.size() < 10) w = 1'b1;
                else r = 1'b1;
            end
            cycle(w, 16'(n), r);
            if (w) n++;
        end
        while (sb.size() > 0) cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);
        chk("wrap_last", 32'(output_1), 32'h0063);
        chk("wrap_cnt", 32'(count), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 32; i++) cycle(1'b1, 16'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_cnt", 32'(count), 32'd32);
        cycle(1'b1, 16'hFFFF, 1'b0);
        chk("fill_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            chk("fill_order", 32'(output_1), 32'(i));
        end
        cycle(1'b0, 16'h0000, 1'b0);
        chk("fill_drained", 32'(empty), 32'd1);

        // Full with simultaneous wr and rd
        async_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0);
        cycle(1'b1, 16'h5555, 1'b1);
        chk("fullboth_data", 32'(output_1), 32'h0100);
        chk("fullboth_cnt", 32'(count), 32'd32);
        chk("fullboth_ovf", 32'(overflow), 32'd0);
        while (sb.size() > 0) cycle(1'b0, 16'h0000, 1'b1);
        chk("fullboth_tail", 32'(output_1), 32'h5555);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h0A00 + i), 1'b0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1);
        async_reset();
        cycle(1'b1, 16'hBEEF, 1'b0);
        cycle(1'b1, 16'hCAFE, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("post_rst_a", 32'(output_1), 32'hBEEF);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("post_rst_b", 32'(output_1), 32'hCAFE);
        cycle(1'b0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
